pwm_tone_mixer: RTL and testbench

//  Parametrised multi-channel tone generator; successor to the single-voice PWM note player.

---
 rtl/tone_pkg.sv | 21 ++
 rtl/tone_channel.sv | 86 ++++++++
 rtl/pwm_tone_mixer.sv | 88 ++++++++
 tb/tb_pwm_tone_mixer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the multi-channel PWM tone mixer.
package tone_pkg;

  typedef enum logic {CH_IDLE, CH_PLAY} ch_state_t;

  // Half-period counts in clk cycles for a 50 MHz clock.
  typedef logic [18:0] note_t;
  localparam note_t DNOTEL = 19'd170265; // D3
  localparam note_t ENOTE  = 19'd151685; // E3
  localparam note_t FNOTE  = 19'd143172; // F3
  localparam note_t GNOTE  = 19'd127551; // G3
  localparam note_t ANOTE  = 19'd113636; // A3
  localparam note_t BNOTE  = 19'd101239; // B3
  localparam note_t CNOTE  = 19'd95556;  // C4
  localparam note_t DNOTE  = 19'd85131;  // D4
  localparam note_t LOW    = 19'd454545; // 55 Hz game-over drone

  // 1 ms duration tick at 50 MHz.
  localparam int unsigned DEFAULT_TICK_DIV = 50000;

endpackage

// File: rtl/tone_channel.sv
// One tone voice: accepts a note over valid/ready, plays a square wave
// for a number of duration ticks, then returns to idle.
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned PERIOD_W = 19,
  parameter int unsigned DUR_W    = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enable,
  input  logic                tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PERIOD_W-1:0] req_period,
  input  logic [DUR_W-1:0]    req_dur,
  output logic                busy,
  output logic                level
);

  ch_state_t           state, state_next;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] phase;
  logic [DUR_W-1:0]    dur;
  logic                load;
  logic                done;

  // A zero-duration request is accepted but consumed as a no-op.
  assign load = req_valid && req_ready && (req_dur != '0);
  // tick already carries enable, so a frozen channel never finishes.
  assign done = (state == CH_PLAY) && tick && (dur == DUR_W'(1));

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= CH_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CH_IDLE: if (load) state_next = CH_PLAY;
      CH_PLAY: if (done) state_next = CH_IDLE;
      default: state_next = CH_IDLE;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    req_ready = (state == CH_IDLE) && enable;
    busy      = (state == CH_PLAY);
  end

  // Note datapath: phase/level square wave and remaining duration.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      period <= '0;
      phase  <= '0;
      dur    <= '0;
      level  <= 1'b0;
    end else if (load) begin
      period <= req_period;
      dur    <= req_dur;
      phase  <= '0;
      level  <= 1'b0;
    end else if ((state == CH_PLAY) && enable) begin
      if (done) begin
        phase <= '0;
        level <= 1'b0;
      end else begin
        if (tick) dur <= dur - DUR_W'(1);
        if (period == '0) begin
          phase <= '0;
          level <= 1'b0;
        end else if (phase == period - PERIOD_W'(1)) begin
          phase <= '0;
          level <= ~level;
        end else begin
          phase <= phase + PERIOD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_tone_mixer.sv
// Multi-channel tone generator: shared duration prescaler, NUM_CH tone
// channels, and a popcount PWM mixer driving one speaker pin.
module pwm_tone_mixer
  import tone_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PERIOD_W = 19,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       enable,
  input  logic                       mute,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*PERIOD_W-1:0] req_period,
  input  logic [NUM_CH*DUR_W-1:0]    req_dur,
  output logic [NUM_CH-1:0]          busy,
  output logic                       tick_o,
  output logic                       out
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned SUM_W = $clog2(NUM_CH + 1);

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [NUM_CH-1:0] level;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  carrier;

  // Duration prescaler: 0..TICK_DIV-1, frozen while disabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == CNT_W'(TICK_DIV - 1)) cnt <= '0;
      else                             cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick   = enable && (cnt == CNT_W'(TICK_DIV - 1));
  assign tick_o = tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_channel #(
      .PERIOD_W (PERIOD_W),
      .DUR_W    (DUR_W)
    ) u_ch (
      .clk        (clk),
      .nrst       (nrst),
      .enable     (enable),
      .tick       (tick),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_period (req_period[g*PERIOD_W +: PERIOD_W]),
      .req_dur    (req_dur[g*DUR_W +: DUR_W]),
      .busy       (busy[g]),
      .level      (level[g])
    );
  end

  // Count of channels currently driving a high level.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(level[i]);
    end
  end

  // PWM carrier 0..NUM_CH-1; stays at 0 when NUM_CH is 1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      carrier <= '0;
    end else if (enable) begin
      if (carrier == SUM_W'(NUM_CH - 1)) carrier <= '0;
      else                               carrier <= carrier + SUM_W'(1);
    end
  end

  // Registered speaker output.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) out <= 1'b0;
    else       out <= (carrier < sum) && enable && !mute;
  end

endmodule

// File: tb/tb_pwm_tone_mixer.sv
// Self-checking bench for pwm_tone_mixer (NUM_CH=2, TICK_DIV=10).
module tb_pwm_tone_mixer;

  localparam int NCH = 2;
  localparam int PW  = 19;
  localparam int DW  = 8;
  localparam int TD  = 10;

  logic              clk = 1'b0;
  logic              nrst;
  logic              enable;
  logic              mute;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*PW-1:0] req_period;
  logic [NCH*DW-1:0] req_dur;
  logic [NCH-1:0]    busy;
  logic              tick_o;
  logic              out;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b1;

  pwm_tone_mixer #(
    .NUM_CH   (NCH),
    .PERIOD_W (PW),
    .DUR_W    (DW),
    .TICK_DIV (TD)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .mute       (mute),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_period (req_period),
    .req_dur    (req_dur),
    .busy       (busy),
    .tick_o     (tick_o),
    .out        (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: en_cnt counts enabled clock edges since reset, so the
  // prescaler value is en_cnt % TD and the carrier is en_cnt % NCH. A playing
  // channel's level is the parity of (enabled cycles since entry / period).
  int en_cnt = 0;
  bit m_busy [NCH];
  int m_per  [NCH];
  int m_rem  [NCH];
  int m_el   [NCH];
  bit m_out = 1'b0;
  bit m_tk;
  int m_sum;
  bit m_nxt;

  initial for (int i = 0; i < NCH; i++) begin
    m_busy[i] = 0; m_per[i] = 0; m_rem[i] = 0; m_el[i] = 0;
  end

  function automatic bit m_level(input int i);
    return m_busy[i] && (m_per[i] != 0) && (((m_el[i] / m_per[i]) % 2) == 1);
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_cnt = 0;
      m_out  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_busy[i] = 0; m_per[i] = 0; m_rem[i] = 0; m_el[i] = 0;
      end
    end else begin
      m_tk  = enable && ((en_cnt % TD) == TD - 1);
      m_sum = 0;
      for (int i = 0; i < NCH; i++) m_sum += int'(m_level(i));
      m_nxt = enable && !mute && ((en_cnt % NCH) < m_sum);
      for (int i = 0; i < NCH; i++) begin
        if (!m_busy[i]) begin
          if (enable && req_valid[i] && (req_dur[i*DW +: DW] != 0)) begin
            m_busy[i] = 1;
            m_per[i]  = int'(req_period[i*PW +: PW]);
            m_rem[i]  = int'(req_dur[i*DW +: DW]);
            m_el[i]   = 0;
          end
        end else if (enable) begin
          m_el[i]++;
          if (m_tk) begin
            if (m_rem[i] == 1) m_busy[i] = 0;
            else               m_rem[i]--;
          end
        end
      end
      if (enable) en_cnt++;
      m_out = m_nxt;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      logic [NCH-1:0] e_busy, e_rdy;
      for (int i = 0; i < NCH; i++) begin
        e_busy[i] = m_busy[i];
        e_rdy[i]  = !m_busy[i] && enable;
      end
      chk("busy", int'(busy), int'(e_busy));
      chk("req_ready", int'(req_ready), int'(e_rdy));
      chk("tick_o", int'(tick_o), int'(enable && ((en_cnt % TD) == TD - 1)));
      chk("out", int'(out), int'(m_out));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy != '0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nb, no, nt, run, max_run;
    nrst = 1'b0; enable = 1'b0; mute = 1'b0;
    req_valid = '0; req_period = '0; req_dur = '0;
    repeat (3) step();

    // Reset state.
    chk("rst_busy", int'(busy), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_ready", int'(req_ready), 0);

    // Test 1: ch0 period=3 dur=2 from a freshly reset prescaler.
    nrst = 1'b1; enable = 1'b1;
    req_period[0 +: PW] = 19'd3; req_dur[0 +: DW] = 8'd2; req_valid = 2'b01;
    #1 chk("t1_ready_idle", int'(req_ready), 3);
    step();
    req_valid = '0;
    nb = 0; no = 0; nt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1_busy_next_cycle", int'(busy[0]), 1);
      nb += int'(busy[0]); no += int'(out); nt += int'(tick_o);
    end
    chk("t1_busy_cycles", nb, 19);
    chk("t1_out_high_cycles", no, 6);
    chk("t1_tick_pulses", nt, 3);
    chk("t1_out_after", int'(out), 0);

    // Test 2: both channels in the same cycle.
    step();
    req_period[0 +: PW] = 19'd4; req_period[PW +: PW] = 19'd6;
    req_dur[0 +: DW] = 8'd5; req_dur[DW +: DW] = 8'd5; req_valid = 2'b11;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t2_ready_drop", int'(req_ready), 0);
    chk("t2_both_busy", int'(busy), 3);
    run = 0; max_run = 0;
    for (int i = 0; i < 60 && busy != '0; i++) begin
      @(negedge clk);
      run = out ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("t2_full_duty_seen", int'(max_run >= 2), 1);
    wait_idle("t2_idle", 100);

    // Test 3: zero-duration request is a no-op.
    step();
    req_period[0 +: PW] = 19'd3; req_dur[0 +: DW] = 8'd0; req_valid = 2'b01;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t3_busy0", int'(busy[0]), 0);
    chk("t3_ready0", int'(req_ready[0]), 1);
    chk("t3_out", int'(out), 0);

    // Test 4: freeze mid-note with enable=0.
    step();
    req_period[0 +: PW] = 19'd3; req_dur[0 +: DW] = 8'd3; req_valid = 2'b01;
    step();
    req_valid = '0;
    repeat (15) step();
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4_frozen_out", int'(out), 0);
      chk("t4_frozen_tick", int'(tick_o), 0);
      chk("t4_frozen_busy", int'(busy[0]), 1);
    end
    step();
    enable = 1'b1;
    wait_idle("t4_idle", 100);

    // Test 5a: mute during a note; busy still ends on schedule.
    step();
    mute = 1'b1;
    req_period[0 +: PW] = 19'd2; req_dur[0 +: DW] = 8'd2; req_valid = 2'b01;
    step();
    req_valid = '0;
    no = 0;
    for (int i = 0; i < 40 && busy != '0; i++) begin
      @(negedge clk);
      no += int'(out);
    end
    chk("t5_muted_out", no, 0);
    wait_idle("t5_mute_idle", 10);
    // Test 5b: rest note on ch1.
    step();
    mute = 1'b0;
    req_period[PW +: PW] = 19'd0; req_dur[DW +: DW] = 8'd2; req_valid = 2'b10;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t5_rest_busy", int'(busy[1]), 1);
    no = 0;
    for (int i = 0; i < 40 && busy != '0; i++) begin
      @(negedge clk);
      no += int'(out);
    end
    chk("t5_rest_out", no, 0);
    wait_idle("t5_rest_idle", 10);

    // Test 6: asynchronous reset mid-note, then a fresh note.
    step();
    req_period[0 +: PW] = 19'd3; req_dur[0 +: DW] = 8'd4; req_valid = 2'b01;
    step();
    req_valid = '0;
    repeat (12) step();
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_out", int'(out), 0);
    chk("t6_rst_tick", int'(tick_o), 0);
    step();
    nrst = 1'b1;
    #1 chk("t6_ready_after", int'(req_ready), 3);
    req_period[PW +: PW] = 19'd5; req_dur[DW +: DW] = 8'd1; req_valid = 2'b10;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t6_new_busy", int'(busy), 2);
    wait_idle("t6_idle", 30);

    repeat (3) step();
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
